snitch_fpu_wb_arb: RTL and testbench
====================================

Name: snitch_fpu_wb_arb

Overview:
- Sits directly downstream of the Snitch FPU wrapper.
- Buffers FPU results (result/status/tag) in a small in-order FIFO and routes each one by tag to its destination:
  - results for the FP register file, where they are arbitrated against FP load data from the LSU;
  - results returned to the integer core (compares, classify, fp-to-int conversions).
- Optionally accumulates the RISC-V fflags (floating-point exception flags).

Parameters:
- FLEN, 64, FP datapath width.
- FifoDepth, 2, FPU result FIFO entries (≥1).
- MaxStall, 4, consecutive lost FPR-write arbitrations after which the FPU is forced to win (≥1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- fpu_result_i  in  FLEN  FPU result
- fpu_status_i  in  5  FPU exception flags {NV,DZ,OF,UF,NX}
- fpu_tag_i  in  6  tag; [5]=1 integer destination, [4:0]=rd
- fpu_valid_i  in  1  FPU result valid
- fpu_ready_o  out  1  FIFO can accept
- lsu_data_i  in  FLEN  FP load data
- lsu_rd_i  in  5  FP load destination
- lsu_valid_i  in  1  load data valid
- lsu_ready_o  out  1  load granted this cycle
- fpr_we_o  out  1  FP regfile write enable (registered)
- fpr_waddr_o  out  5  FP regfile write address (registered)
- fpr_wdata_o  out  FLEN  FP regfile write data (registered)
- int_valid_o  out  1  integer result valid
- int_rd_o  out  5  integer destination
- int_data_o  out  32  integer result, fpu_result[31:0]
- int_ready_i  in  1  core accepts integer result
- fflags_o  out  5  sticky accumulated flags
- fflags_clr_i  in  1  clear fflags
- fifo_empty_o  out  1  no FPU result pending

Behaviour:
- Reset: clock is clk_i; reset rst_i is asynchronous, active-high. Asserting rst_i at any time, including mid-operation:
  - empties the FIFO and drops in-flight entries;
  - zeroes the stall counter, fflags_o and the fpr_* output registers;
  - after reset: fpu_ready_o=1 (once out of reset), int_valid_o=0, lsu_ready_o=0, fifo_empty_o=1.
- FIFO push and flow control:
  - Push on fpu_valid_i && fpu_ready_o.
  - fpu_ready_o = !full; no write-through when full, even if a pop occurs in the same cycle.
  - No bypass: an entry pushed in cycle N is at the head no earlier than N+1.
- Integer-destination head (tag[5]=1):
  - int_valid_o=1 with head rd/data, combinational from the head.
  - Pop on int_ready_i.
  - Does not use the FPR port; the LSU may write the FPR in the same cycle.
- FP-destination head (tag[5]=0) arbitrates with the LSU for the single FPR write:
  - Default: LSU wins.
  - The FPU wins if lsu_valid_i=0, or if stall_cnt==MaxStall.
  - A lost arbitration (head FP-valid && lsu_valid_i && LSU granted) increments stall_cnt.
  - An FPU grant resets stall_cnt to 0.
  - stall_cnt holds when the head is not FP-valid. It saturates at MaxStall and never wraps.
- Grant outputs:
  - lsu_ready_o = LSU granted this cycle (combinational).
  - The winner's rd/data are registered; fpr_we_o=1 the following cycle, otherwise fpr_we_o=0.
- Latency:
  - FPU→FPR: accept in N, fpr_we_o earliest in N+2.
  - FPU→int: int_valid_o earliest in N+1.
  - LSU→FPR: granted in N, fpr_we_o in N+1.
- Ordering: FIFO is strictly in order. An integer head blocks younger FP entries until popped.
- fifo_empty_o = FIFO count==0.

Optional Feature:
- SNITCH_FPU_WB_FFLAGS_EN defined:
  - On every FIFO pop, fflags_o <= (fflags_clr_i ? 0 : fflags_o) | popped status.
  - Clear with no pop → 0. Clear and pop in the same cycle → popped status only.
- Undefined: fflags_o tied to 0; fflags_clr_i ignored; no flag registers.

Test Plan:
- Single FP result, tag=0x03, result=0x3FF0_0000_0000_0000, no LSU traffic → fpr_we_o=1, waddr=3, wdata=0x3FF0…0 exactly 2 cycles after acceptance; fifo_empty_o=1 afterwards.
- Integer result, tag=0x25, result low word 0x1; int_ready_i held 0 for 3 cycles then 1 → int_valid_o/int_rd_o=5 stable for 4 cycles, pop on the 4th; no fpr_we_o.
- FIFO full: FifoDepth=2, 3 back-to-back FP pushes with lsu_valid_i=1 continuously → fpu_ready_o=0 after 2 pushes; FPU wins only on the 5th lost cycle (MaxStall=4), then stall_cnt=0; every write appears once, in push order.
- Ordering: int entry (tag=0x21) then FP entry (tag=0x02); int_ready_i=0 for 2 cycles → no FPR write of rd 2 until the int pop; LSU write rd 7 proceeds meanwhile.
- fflags (macro on): pop statuses 0x01 then 0x10 → fflags_o=0x11; clear together with a pop of status 0x04 → 0x04; clear alone → 0x00. Macro off → fflags_o always 0.
- Reset mid-operation: 2 FIFO entries, fpr_we_o=1; assert rst_i asynchronously → all outputs 0 and fifo_empty_o=1 immediately; after deassert, no stale write or int_valid_o.

Source files
------------

// File: rtl/snitch_fpu_wb_arb.sv
// snitch_fpu_wb_arb: write-back arbiter behind the Snitch FPU wrapper.
// FPU results are buffered in a small in-order FIFO. Each result is then
// routed by tag, either to the integer core or to the FP register file.
// On the FP register file port, FPU results share the single write port
// with LSU load data.
// Optional feature macro: SNITCH_FPU_WB_FFLAGS_EN enables the sticky
// fflags accumulator. When it is undefined, fflags_o is tied to zero.
module snitch_fpu_wb_arb #(
    parameter int unsigned FLEN      = 64,
    parameter int unsigned FifoDepth = 2,
    parameter int unsigned MaxStall  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [FLEN-1:0] fpu_result_i,
    input  logic [4:0]      fpu_status_i,
    input  logic [5:0]      fpu_tag_i,
    input  logic            fpu_valid_i,
    output logic            fpu_ready_o,
    input  logic [FLEN-1:0] lsu_data_i,
    input  logic [4:0]      lsu_rd_i,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    output logic            fpr_we_o,
    output logic [4:0]      fpr_waddr_o,
    output logic [FLEN-1:0] fpr_wdata_o,
    output logic            int_valid_o,
    output logic [4:0]      int_rd_o,
    output logic [31:0]     int_data_o,
    input  logic            int_ready_i,
    output logic [4:0]      fflags_o,
    input  logic            fflags_clr_i,
    output logic            fifo_empty_o
);

    localparam int unsigned PtrW   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW   = $clog2(FifoDepth + 1);
    localparam int unsigned StallW = $clog2(MaxStall + 1);

    logic [FLEN-1:0]   mem_result [FifoDepth];
    logic [5:0]        mem_tag    [FifoDepth];
    logic [PtrW-1:0]   rd_ptr;
    logic [PtrW-1:0]   wr_ptr;
    logic [CntW-1:0]   count;
    logic [StallW-1:0] stall_cnt;

    logic full;
    logic push;
    logic pop;
    logic head_valid;
    logic head_int;
    logic head_fp;
    logic fpu_grant;
    logic lsu_grant;
    logic [FLEN-1:0] head_result;
    logic [5:0]      head_tag;

    assign full         = (count == CntW'(FifoDepth));
    assign fpu_ready_o  = !full;
    assign fifo_empty_o = (count == '0);
    assign push         = fpu_valid_i && !full;

    assign head_valid  = !fifo_empty_o;
    assign head_result = mem_result[rd_ptr];
    assign head_tag    = mem_tag[rd_ptr];
    assign head_int    = head_valid && head_tag[5];
    assign head_fp     = head_valid && !head_tag[5];

    // The LSU wins the FPR port by default. The FPU head wins when the LSU
    // is idle, or once it has been starved for MaxStall cycles in a row.
    assign fpu_grant   = head_fp && (!lsu_valid_i || (stall_cnt == StallW'(MaxStall)));
    assign lsu_grant   = lsu_valid_i && !fpu_grant;
    assign lsu_ready_o = lsu_grant;

    assign pop = (head_int && int_ready_i) || fpu_grant;

    assign int_valid_o = head_int;
    assign int_rd_o    = head_tag[4:0];
    assign int_data_o  = head_result[31:0];

    // FIFO payload storage; only the pointers need a reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_result[wr_ptr] <= fpu_result_i;
            mem_tag[wr_ptr]    <= fpu_tag_i;
        end
    end

    // FIFO pointers and occupancy. A push while full is refused, even when
    // a pop happens in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Starvation counter for the FP head. It saturates and never wraps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (fpu_grant) begin
            stall_cnt <= '0;
        end else if (head_fp && lsu_valid_i && (stall_cnt != StallW'(MaxStall))) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Register the winner of the FPR port. Address and data hold when idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fpr_we_o    <= 1'b0;
            fpr_waddr_o <= '0;
            fpr_wdata_o <= '0;
        end else begin
            fpr_we_o <= fpu_grant || lsu_grant;
            if (fpu_grant) begin
                fpr_waddr_o <= head_tag[4:0];
                fpr_wdata_o <= head_result;
            end else if (lsu_grant) begin
                fpr_waddr_o <= lsu_rd_i;
                fpr_wdata_o <= lsu_data_i;
            end
        end
    end

`ifdef SNITCH_FPU_WB_FFLAGS_EN
    logic [4:0] mem_status [FifoDepth];
    logic [4:0] fflags_q;

    // Status storage alongside the FIFO payload.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_status[wr_ptr] <= fpu_status_i;
        end
    end

    // Sticky flags. A clear and a pop in the same cycle leave only the
    // popped status.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fflags_q <= '0;
        end else if (pop) begin
            fflags_q <= (fflags_clr_i ? 5'd0 : fflags_q) | mem_status[rd_ptr];
        end else if (fflags_clr_i) begin
            fflags_q <= '0;
        end
    end

    assign fflags_o = fflags_q;
`else
    logic unused_flags;
    assign unused_flags = ^{fpu_status_i, fflags_clr_i};
    assign fflags_o     = '0;
`endif

endmodule

// File: tb/tb_snitch_fpu_wb_arb.sv
// tb_snitch_fpu_wb_arb: randomized and directed bench for snitch_fpu_wb_arb.
// The expected outputs come from a queue-based model of the write-back rules.
// The model is pinned by a few literal expectations. Honours
// SNITCH_FPU_WB_FFLAGS_EN when it is defined for the build.
module tb_snitch_fpu_wb_arb;

    localparam int DEPTH    = 2;
    localparam int MAXSTALL = 4;
`ifdef SNITCH_FPU_WB_FFLAGS_EN
    localparam bit FFLAGS_ON = 1'b1;
`else
    localparam bit FFLAGS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inFv = 1'b0;
    logic [63:0] inRes = '0;
    logic [4:0]  inSt = '0;
    logic [5:0]  inTag = '0;
    logic        inLv = 1'b0;
    logic [63:0] inLd = '0;
    logic [4:0]  inLrd = '0;
    logic        inIr = 1'b0;
    logic        inClr = 1'b0;

    logic        fpuReady;
    logic        lsuReady;
    logic        fprWe;
    logic [4:0]  fprWaddr;
    logic [63:0] fprWdata;
    logic        intValid;
    logic [4:0]  intRd;
    logic [31:0] intData;
    logic [4:0]  fflags;
    logic        fifoEmpty;

    snitch_fpu_wb_arb #(.FLEN(64), .FifoDepth(DEPTH), .MaxStall(MAXSTALL)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fpu_result_i (inRes),
        .fpu_status_i (inSt),
        .fpu_tag_i    (inTag),
        .fpu_valid_i  (inFv),
        .fpu_ready_o  (fpuReady),
        .lsu_data_i   (inLd),
        .lsu_rd_i     (inLrd),
        .lsu_valid_i  (inLv),
        .lsu_ready_o  (lsuReady),
        .fpr_we_o     (fprWe),
        .fpr_waddr_o  (fprWaddr),
        .fpr_wdata_o  (fprWdata),
        .int_valid_o  (intValid),
        .int_rd_o     (intRd),
        .int_data_o   (intData),
        .int_ready_i  (inIr),
        .fflags_o     (fflags),
        .fflags_clr_i (inClr),
        .fifo_empty_o (fifoEmpty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  st;
        logic [5:0]  tag;
    } entry_t;

    entry_t      mq[$];
    int          mStall;
    logic        mWe;
    logic [4:0]  mWaddr;
    logic [63:0] mWdata;
    logic [4:0]  mFflags;

    int nVec  = 0;
    int nFail = 0;

    logic        sFpuReady, sLsuReady, sFprWe, sIntValid, sEmpty;
    logic [4:0]  sFprWaddr, sIntRd, sFflags;
    logic [63:0] sFprWdata;
    logic [31:0] sIntData;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearModel();
        mq.delete();
        mStall  = 0;
        mWe     = 1'b0;
        mWaddr  = '0;
        mWdata  = '0;
        mFflags = '0;
    endtask

    task automatic setIdle();
        inFv  = 1'b0;
        inRes = '0;
        inSt  = '0;
        inTag = '0;
        inLv  = 1'b0;
        inLd  = '0;
        inLrd = '0;
        inIr  = 1'b0;
        inClr = 1'b0;
    endtask

    // One cycle: the inputs are already set just after the previous rising edge.
    // Sample at the falling edge, compare against the model, then advance the model.
    task automatic applyStimulus();
        bit     full, headFp, headInt, fpuWin, lsuWin, pop, push;
        entry_t head;
        @(negedge clk);
        #1;
        full    = (mq.size() == DEPTH);
        headFp  = (mq.size() > 0) && !mq[0].tag[5];
        headInt = (mq.size() > 0) && mq[0].tag[5];
        if (mq.size() > 0) head = mq[0];
        fpuWin  = headFp && (!inLv || mStall == MAXSTALL);
        lsuWin  = inLv && !fpuWin;

        sFpuReady = fpuReady; sLsuReady = lsuReady; sFprWe = fprWe;
        sFprWaddr = fprWaddr; sFprWdata = fprWdata; sIntValid = intValid;
        sIntRd = intRd; sIntData = intData; sFflags = fflags; sEmpty = fifoEmpty;

        checkOutput("fpu_ready", fpuReady, !full);
        checkOutput("fifo_empty", fifoEmpty, mq.size() == 0);
        checkOutput("lsu_ready", lsuReady, lsuWin);
        checkOutput("int_valid", intValid, headInt);
        if (headInt) begin
            checkOutput("int_rd", intRd, head.tag[4:0]);
            checkOutput("int_data", intData, head.res[31:0]);
        end
        checkOutput("fpr_we", fprWe, mWe);
        if (mWe) begin
            checkOutput("fpr_waddr", fprWaddr, mWaddr);
            checkOutput("fpr_wdata", fprWdata, mWdata);
        end
        checkOutput("fflags", fflags, mFflags);

        pop  = (headInt && inIr) || fpuWin;
        push = inFv && !full;
        if (FFLAGS_ON) begin
            if (pop) mFflags = (inClr ? 5'd0 : mFflags) | head.st;
            else if (inClr) mFflags = 5'd0;
        end
        if (fpuWin) mStall = 0;
        else if (headFp && inLv && mStall < MAXSTALL) mStall++;
        mWe = fpuWin || lsuWin;
        if (fpuWin) begin
            mWaddr = head.tag[4:0];
            mWdata = head.res;
        end else if (lsuWin) begin
            mWaddr = inLrd;
            mWdata = inLd;
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{res: inRes, st: inSt, tag: inTag});
        @(posedge clk);
        #1;
    endtask

    // Assert the reset in the middle of a cycle and check that the outputs clear at once.
    task automatic applyReset();
        setIdle();
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_fpr_we", fprWe, 1'b0);
        checkOutput("rst_fpr_waddr", fprWaddr, 5'd0);
        checkOutput("rst_fpr_wdata", fprWdata, 64'd0);
        checkOutput("rst_int_valid", intValid, 1'b0);
        checkOutput("rst_lsu_ready", lsuReady, 1'b0);
        checkOutput("rst_fifo_empty", fifoEmpty, 1'b1);
        checkOutput("rst_fflags", fflags, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        clearModel();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        setIdle();
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    int streak;
    bit accepted;

    initial begin
        clearModel();
        setIdle();
        repeat (2) @(posedge clk);
        #1;
        applyReset();
        idleCycles(2);

        // Single FP result: write appears two cycles after acceptance.
        inFv = 1'b1; inTag = 6'h03; inRes = 64'h3FF0_0000_0000_0000;
        applyStimulus();
        setIdle();
        applyStimulus();
        checkOutput("t1_we_early", sFprWe, 1'b0);
        applyStimulus();
        checkOutput("t1_we", sFprWe, 1'b1);
        checkOutput("t1_waddr", sFprWaddr, 5'd3);
        checkOutput("t1_wdata", sFprWdata, 64'h3FF0_0000_0000_0000);
        checkOutput("t1_empty", sEmpty, 1'b1);

        // Integer result held for three cycles, popped on the fourth.
        inFv = 1'b1; inTag = 6'h25; inRes = 64'h1;
        applyStimulus();
        setIdle();
        for (int i = 0; i < 4; i++) begin
            inIr = (i == 3);
            applyStimulus();
            checkOutput("t2_int_valid", sIntValid, 1'b1);
            checkOutput("t2_int_rd", sIntRd, 5'd5);
            checkOutput("t2_int_data", sIntData, 32'h1);
            checkOutput("t2_no_we", sFprWe, 1'b0);
        end
        setIdle();
        applyStimulus();
        checkOutput("t2_int_gone", sIntValid, 1'b0);
        checkOutput("t2_no_we_end", sFprWe, 1'b0);

        // FIFO full under continuous LSU pressure; forced FPU win after MaxStall losses.
        inLv = 1'b1; inLrd = 5'd9; inLd = 64'hAAAA;
        inFv = 1'b1; inTag = 6'h0A; inRes = 64'hA0;
        applyStimulus();
        inTag = 6'h0B; inRes = 64'hB0;
        applyStimulus();
        streak = sLsuReady ? 1 : 0;
        inTag = 6'h0C; inRes = 64'hC0;
        applyStimulus();
        checkOutput("t3_full", sFpuReady, 1'b0);
        if (sLsuReady) streak++;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            applyStimulus();
            if (sFpuReady) accepted = 1'b1;
            else if (sLsuReady && streak == i + 2) streak++;
        end
        checkOutput("t3_accepted", accepted, 1'b1);
        checkOutput("t3_lost_streak", streak, MAXSTALL);
        inFv = 1'b0;
        for (int i = 0; i < 12; i++) applyStimulus();
        idleCycles(6);

        // Integer head blocks a younger FP entry; the LSU still writes meanwhile.
        inFv = 1'b1; inTag = 6'h21; inRes = 64'h55;
        applyStimulus();
        inTag = 6'h02; inRes = 64'h22; inLv = 1'b1; inLrd = 5'd7; inLd = 64'h77;
        applyStimulus();
        checkOutput("t4_lsu_grant", sLsuReady, 1'b1);
        setIdle();
        applyStimulus();
        checkOutput("t4_lsu_write", sFprWe, 1'b1);
        checkOutput("t4_lsu_waddr", sFprWaddr, 5'd7);
        checkOutput("t4_int_valid", sIntValid, 1'b1);
        inIr = 1'b1;
        applyStimulus();
        checkOutput("t4_blocked", sFprWe, 1'b0);
        setIdle();
        applyStimulus();
        checkOutput("t4_still_blocked", sFprWe, 1'b0);
        applyStimulus();
        checkOutput("t4_fp_write", sFprWe, 1'b1);
        checkOutput("t4_fp_waddr", sFprWaddr, 5'd2);

        // Sticky flags: accumulate, clear with a pop, then clear alone.
        inClr = 1'b1;
        applyStimulus();
        setIdle();
        inFv = 1'b1; inTag = 6'h01; inSt = 5'h01;
        applyStimulus();
        setIdle();
        applyStimulus();
        inFv = 1'b1; inTag = 6'h01; inSt = 5'h10;
        applyStimulus();
        setIdle();
        applyStimulus();
        applyStimulus();
        checkOutput("t5_accum", sFflags, FFLAGS_ON ? 5'h11 : 5'h00);
        inFv = 1'b1; inTag = 6'h01; inSt = 5'h04;
        applyStimulus();
        setIdle();
        inClr = 1'b1;
        applyStimulus();
        setIdle();
        applyStimulus();
        checkOutput("t5_clr_pop", sFflags, FFLAGS_ON ? 5'h04 : 5'h00);
        inClr = 1'b1;
        applyStimulus();
        setIdle();
        applyStimulus();
        checkOutput("t5_clr_alone", sFflags, 5'h00);

        // Reset in the middle of operation, with two entries pending and a write in flight.
        inFv = 1'b1; inTag = 6'h03; inRes = 64'h33; inLv = 1'b1; inLrd = 5'd8; inLd = 64'h88;
        applyStimulus();
        inTag = 6'h04; inRes = 64'h44;
        applyStimulus();
        inFv = 1'b0;
        applyStimulus();
        checkOutput("t6_we_before", sFprWe, 1'b1);
        checkOutput("t6_two_pending", sEmpty, 1'b0);
        applyReset();
        idleCycles(4);
        checkOutput("t6_no_stale_we", sFprWe, 1'b0);
        checkOutput("t6_no_stale_int", sIntValid, 1'b0);

        // Randomized traffic with one reset along the way.
        for (int i = 0; i < 3000; i++) begin
            inFv  = 1'($urandom_range(0, 1));
            inRes = {$urandom, $urandom};
            inSt  = 5'($urandom);
            inTag = 6'($urandom);
            inLv  = ($urandom_range(0, 2) == 0);
            inLd  = {$urandom, $urandom};
            inLrd = 5'($urandom);
            inIr  = 1'($urandom_range(0, 1));
            inClr = ($urandom_range(0, 7) == 0);
            applyStimulus();
            if (i == 1500) applyReset();
        end
        idleCycles(8);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
